// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter only has to reach WIDTH-1, and it must be at least one bit wide.
  function automatic int cntWidth(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result handshake bundle between operand source, controller and consumer.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             busy;

  modport master (
    output start_valid, a, b, bin, res_ready,
    input  start_ready, res_valid, diff, bout, zero, busy
  );

  modport slave (
    input  start_valid, a, b, bin, res_ready,
    output start_ready, res_valid, diff, bout, zero, busy
  );
endinterface

// File: rtl/serial_sub_ctrl_fs_bit_cell.sv
// Combinational 1-bit full subtractor: the only arithmetic in the serial datapath.
module fs_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & (y ^ bi)) | (y & bi);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtractor: one full-subtractor cell is reused LSB first,
// with the running borrow held in a register between bits.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  ctrl
);
  localparam int CW = cntWidth(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_resSh;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_startReady;
  logic             r_resValid;
  logic             r_busy;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_resNext;

  fs_bit_cell u_cell (
    .x  (r_aSh[0]),
    .y  (r_bSh[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_resNext = {w_d, r_resSh[WIDTH-1:1]};

  // Results are published only on the final bit, so diff/bout/zero keep the
  // previous answer while a new subtraction is still shifting through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_aSh        <= '0;
      r_bSh        <= '0;
      r_resSh      <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_bout       <= 1'b0;
      r_zero       <= 1'b0;
      r_startReady <= 1'b1;
      r_resValid   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ctrl.start_valid) begin
            r_aSh        <= ctrl.a;
            r_bSh        <= ctrl.b;
            r_borrow     <= ctrl.bin;
            r_cnt        <= '0;
            r_state      <= ST_RUN;
            r_startReady <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        ST_RUN: begin
          r_resSh  <= w_resNext;
          r_borrow <= w_bo;
          r_aSh    <= {1'b0, r_aSh[WIDTH-1:1]};
          r_bSh    <= {1'b0, r_bSh[WIDTH-1:1]};
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_diff     <= w_resNext;
            r_bout     <= w_bo;
            r_zero     <= (w_resNext == '0);
            r_state    <= ST_DONE;
            r_resValid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ctrl.res_ready) begin
            r_state      <= ST_IDLE;
            r_resValid   <= 1'b0;
            r_startReady <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resValid   <= 1'b0;
          r_startReady <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.start_ready = r_startReady;
  assign ctrl.res_valid   = r_resValid;
  assign ctrl.diff        = r_diff;
  assign ctrl.bout        = r_bout;
  assign ctrl.zero        = r_zero;
  assign ctrl.busy        = r_busy;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases plus random operands
// compared against a plain-arithmetic reference of a - b - bin.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n = 0;
    while (bus.start_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("startReadyBeforeReq", 64'(bus.start_ready), 64'd1);
    bus.a           = a;
    bus.b           = b;
    bus.bin         = bin;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
  endtask

  // Waits for the result, optionally scrambling the request inputs meanwhile,
  // and checks latency and values against the arithmetic reference.
  task automatic collectResult(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                               input bit scramble, input string tag);
    logic [W:0] full;
    int         lat = 0;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    while (bus.res_valid !== 1'b1 && lat < 50) begin
      if (scramble) begin
        bus.start_valid = 1'($urandom_range(0, 1));
        bus.a           = W'($urandom);
        bus.b           = W'($urandom);
        bus.bin         = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    checkOutput({tag, ".latency"},    64'(lat),             64'(W));
    checkOutput({tag, ".diff"},       64'(bus.diff),        64'(full[W-1:0]));
    checkOutput({tag, ".bout"},       64'(bus.bout),        64'(full[W]));
    checkOutput({tag, ".zero"},       64'(bus.zero),        64'(full[W-1:0] == '0));
    checkOutput({tag, ".startReady"}, 64'(bus.start_ready), 64'd0);
  endtask

  // With res_ready high the controller must be back in IDLE after one edge.
  task automatic retireResult(input string tag);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, ".idleReady"}, 64'(bus.start_ready), 64'd1);
    checkOutput({tag, ".idleValid"}, 64'(bus.res_valid),   64'd0);
    checkOutput({tag, ".idleBusy"},  64'(bus.busy),        64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W-1:0] heldDiff;
    logic         heldBout, heldZero;

    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.bin         = 1'b0;
    bus.res_ready   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset.startReady", 64'(bus.start_ready), 64'd1);
    checkOutput("reset.resValid",   64'(bus.res_valid),   64'd0);
    checkOutput("reset.busy",       64'(bus.busy),        64'd0);
    checkOutput("reset.diff",       64'(bus.diff),        64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operand cases");
    applyStimulus(8'h5A, 8'h23, 1'b0);
    checkOutput("run.busy", 64'(bus.busy), 64'd1);
    collectResult(8'h5A, 8'h23, 1'b0, 1'b0, "5A-23");
    retireResult("5A-23");

    applyStimulus(8'h10, 8'h20, 1'b0);
    collectResult(8'h10, 8'h20, 1'b0, 1'b0, "10-20");
    retireResult("10-20");

    applyStimulus(8'h00, 8'h00, 1'b1);
    collectResult(8'h00, 8'h00, 1'b1, 1'b0, "00-00-1");
    retireResult("00-00-1");

    applyStimulus(8'h77, 8'h77, 1'b0);
    collectResult(8'h77, 8'h77, 1'b0, 1'b0, "77-77");
    retireResult("77-77");

    $display("[TB] backpressure hold");
    bus.res_ready = 1'b0;
    applyStimulus(8'hB4, 8'h4F, 1'b1);
    collectResult(8'hB4, 8'h4F, 1'b1, 1'b0, "bp");
    heldDiff = bus.diff;
    heldBout = bus.bout;
    heldZero = bus.zero;
    for (int i = 0; i < 5; i++) begin
      bus.start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp.resValid",   64'(bus.res_valid),   64'd1);
      checkOutput("bp.startReady", 64'(bus.start_ready), 64'd0);
      checkOutput("bp.diffHeld",   64'(bus.diff),        64'(heldDiff));
      checkOutput("bp.boutHeld",   64'(bus.bout),        64'(heldBout));
      checkOutput("bp.zeroHeld",   64'(bus.zero),        64'(heldZero));
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    retireResult("bp");

    $display("[TB] inputs ignored during RUN");
    applyStimulus(8'hC3, 8'h3C, 1'b0);
    collectResult(8'hC3, 8'h3C, 1'b0, 1'b1, "C3-3C");
    retireResult("C3-3C");

    $display("[TB] random operands");
    for (int i = 0; i < 16; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if (i == 0) begin
        ra = 8'hFF; rb = 8'h00; rbin = 1'b0;
      end else if (i == 1) begin
        ra = 8'h00; rb = 8'hFF; rbin = 1'b1;
      end
      applyStimulus(ra, rb, rbin);
      collectResult(ra, rb, rbin, i[0], $sformatf("rand%0d", i));
      retireResult($sformatf("rand%0d", i));
    end

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(8'h9E, 8'h11, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midReset.resValid",   64'(bus.res_valid),   64'd0);
    checkOutput("midReset.busy",       64'(bus.busy),        64'd0);
    checkOutput("midReset.startReady", 64'(bus.start_ready), 64'd1);
    checkOutput("midReset.diff",       64'(bus.diff),        64'd0);
    checkOutput("midReset.bout",       64'(bus.bout),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postReset.resValid", 64'(bus.res_valid), 64'd0);
    applyStimulus(8'h01, 8'h02, 1'b0);
    collectResult(8'h01, 8'h02, 1'b0, 1'b0, "01-02");
    retireResult("01-02");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
